// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

    // Controller states; the fourth encoding is illegal and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADD  = 2'b01,
        DONE = 2'b10
    } sa_state_e;

    localparam int SA_DEFAULT_WIDTH = 8;

endpackage : serial_adder_pkg

// File: rtl/half_adder.sv
// Team half_adder cell: one-bit sum and carry of two inputs.
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);

    assign sum_o   = a_i ^ b_i;
    assign carry_o = a_i & b_i;

endmodule : half_adder

// File: rtl/serial_adder_full_adder.sv
// Full-adder slice built from two half_adders and an OR of their carries.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .a_i     (a_i),
        .b_i     (b_i),
        .sum_o   (s0),
        .carry_o (c0)
    );

    half_adder u_ha1 (
        .a_i     (s0),
        .b_i     (cin_i),
        .sum_o   (sum_o),
        .carry_o (c1)
    );

    // Only one of the two half-adder carries can be set at a time.
    assign cout_o = c0 | c1;

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: accepts operands, adds one bit per clock
// LSB first, then holds sum/cout until the consumer takes them.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sa_state_e        state_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sum_q;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] sum_d;

    full_adder u_fa (
        .a_i    (op_a_q[0]),
        .b_i    (op_b_q[0]),
        .cin_i  (carry_q),
        .sum_o  (fa_sum),
        .cout_o (fa_cout)
    );

    // Next sum shift-register value: new bit enters at the MSB (works for WIDTH=1).
    always_comb begin
        // NOTE: assign a full default before the partial overwrite so no latch is inferred.
        sum_d            = sum_q >> 1;
        sum_d[WIDTH-1]   = fa_sum;
    end

    // Controller and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
        end else begin
            // NOTE: non-blocking so every branch reads the pre-edge register values.
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_a_q  <= a;
                        op_b_q  <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    sum_q   <= sum_d;
                    carry_q <= fa_cout;
                    op_a_q  <= op_a_q >> 1;
                    op_b_q  <= op_b_q >> 1;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Handshake flags are decoded from state; in_ready is also gated by reset.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = carry_q;

endmodule : serial_adder

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around the team's half_adder cell.
- Consumes two operands plus carry-in through a valid/ready handshake, then adds one bit per clock, LSB first, using a full-adder slice made of two half_adders.
- Presents sum and carry-out through an output valid/ready handshake.
- Sits directly downstream of operand generation and upstream of any result consumer. It is the first sequential datapath stage reusing half_adder.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a, b, cin are valid.
- in_ready  output  1  block can accept operands; high only in IDLE and only while rst_n=1.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  sum and cout are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  registered result, equal to (a+b+cin) mod 2^WIDTH.
- cout  output  1  registered carry-out of bit WIDTH-1.

Behaviour:
- Reset:
  - Asserting rst_n low at any time, including mid-ADD or during DONE, forces state=IDLE immediately.
  - On reset: sum=0, cout=0, out_valid=0, internal operand/carry/count registers=0, in_ready=0.
  - Any in-flight operation is discarded; no partial result is ever presented.
  - First accept is possible on the first rising edge with rst_n=1.
- State machine, held in a registered enum:
  - IDLE:
    - in_ready=1.
    - When in_valid&in_ready is high at an edge: latch a→opA, b→opB, cin→carry; clear bit_cnt and sum shift register; go to ADD.
  - ADD:
    - in_ready=0, out_valid=0.
    - Each edge: full_adder(opA[0], opB[0], carry) produces s, c.
    - sum_reg <= {s, sum_reg[WIDTH-1:1]}; carry <= c; opA, opB shift right by 1; bit_cnt++.
    - When bit_cnt==WIDTH-1 at an edge, that edge performs the final bit and moves to DONE.
  - DONE:
    - out_valid=1. sum and cout (= carry) are held stable.
    - When out_valid&out_ready is high at an edge, go to IDLE.
    - in_valid is ignored in DONE.
- Latency:
  - out_valid rises exactly WIDTH clock edges after the accept edge.
  - With out_ready tied high, the accept-to-accept period is WIDTH+2 cycles.
- in_valid/operands presented while in_ready=0 have no effect; the upstream stage holds them until accepted.
- Outputs are fully registered except in_ready and out_valid, which are decoded from state; no combinational input-to-output path.
- Width rules:
  - bit_cnt is $clog2(WIDTH+1) bits wide.
  - WIDTH=1 means one ADD cycle.
  - Overflow is reported only via cout; no saturation.
- Illegal or unknown state encoding returns to IDLE on the next edge with out_valid=0.

Decomposition:
- serial_adder_pkg:
  - typedef enum logic [1:0] {IDLE, ADD, DONE} sa_state_e;
  - localparam SA_DEFAULT_WIDTH = 8.
- Sub-module full_adder (a, b, cin → sum, cout):
  - two half_adder instances plus an OR of their carries; purely combinational.
  - instantiated once in serial_adder.
- All registers live in serial_adder.

Test Plan:
- Reset mid-operation (WIDTH=8): accept a=8'h12, b=8'h34; drop rst_n 3 cycles later → out_valid=0 and in_ready=0 while rst_n low, sum=0, cout=0; after release in_ready=1 and no result ever appears for the aborted operand.
- Basic add: a=8'h35, b=8'h4A, cin=0 with out_ready=1 → out_valid high exactly 8 edges after accept; sum=8'h7F, cout=0; out_valid high for 1 cycle.
- Carry ripple and overflow:
  - a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1.
  - a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
  - a=0, b=0, cin=1 → sum=8'h01, cout=0.
- Backpressure: result ready while out_ready=0 for 5 cycles → out_valid, sum, cout stable for all 5 cycles; in_ready=0; new in_valid with a=8'hAA is not accepted. Raising out_ready → handshake, then a=8'hAA accepted on the following cycle.
- Back-to-back: in_valid held high with operand pairs (1,2), (3,4), (100,200) and out_ready=1 → results 3, 7, 44 with cout 0, 0, 1, in order, accepts spaced exactly 10 cycles apart, no drops or duplicates.
- WIDTH=1 build: all 8 (a, b, cin) combinations → sum=a^b^cin, cout=majority(a, b, cin), out_valid 1 edge after each accept.
